// File: rtl/se_channel_arbiter.sv
// se_channel_arbiter: priority arbiter that shares one speaker tone output among four sound sources.
// Ports:
//   iClock, iReset     clock and synchronous active-high reset
//   iEnable[3:0]       per-channel request level, bit 3 highest priority, bit 0 background music
//   iFreq[63:0]        packed per-channel frequency, channel n at [16n+15:16n]
//   iMute              silences the output without touching arbitration or counters
//   oEnable, oFreq     tone driver enable and selected frequency (0 when disabled)
//   oGrant[3:0]        one-hot current owner, 0 when nothing is playing
//   oState[1:0]        debug state: 0 IDLE, 1 PLAY, 2 GAP
module se_channel_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [31:0] MIN_HOLD   = 32'd50000,
    parameter logic [31:0] GAP_CYCLES = 32'd5000
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [3:0]  iEnable,
    input  logic [63:0] iFreq,
    input  logic        iMute,
    output logic        oEnable,
    output logic [15:0] oFreq,
    output logic [3:0]  oGrant,
    output logic [1:0]  oState
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] gap_q, gap_d;
    logic        any_en, higher_req;
    logic [1:0]  top_idx;
    logic [3:0]  above_mask;
    assign any_en     = |iEnable[NUM_CH-1:0];
    assign top_idx    = iEnable[3] ? 2'd3 : iEnable[2] ? 2'd2 : iEnable[1] ? 2'd1 : 2'd0;
    // Bits strictly above the current owner; only these may preempt.
    assign above_mask = 4'b1110 << grant_q;
    assign higher_req = |(iEnable & above_mask);
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: if (any_en) begin
                state_d = PLAY;
                grant_d = top_idx;
                hold_d  = 32'd0;
            end
            PLAY: if (!iEnable[grant_q] || (higher_req && hold_q >= MIN_HOLD)) begin
                state_d = GAP;
                gap_d   = 32'd0;
            end else begin
                hold_d = (hold_q >= MIN_HOLD) ? MIN_HOLD : hold_q + 32'd1;
            end
            GAP: begin
                gap_d = gap_q + 32'd1;
                // Requests are only looked at on the last silent cycle.
                if (gap_q == GAP_CYCLES - 32'd1) begin
                    state_d = any_en ? PLAY : IDLE;
                    grant_d = any_en ? top_idx : grant_q;
                    hold_d  = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            hold_q  <= 32'd0;
            gap_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end
    // Frequency passes through live so source sweeps track with no latency.
    assign oEnable = (state_q == PLAY) && !iMute;
    assign oFreq   = oEnable ? iFreq[{grant_q, 4'b0000} +: 16] : 16'd0;
    assign oGrant  = (state_q == PLAY) ? (4'b0001 << grant_q) : 4'b0000;
    assign oState  = state_q;
endmodule

// File: tb/tb_se_channel_arbiter.sv
// tb_se_channel_arbiter: directed plus random checking of se_channel_arbiter against a behavioural model.
module tb_se_channel_arbiter;
    localparam int MH = 4;
    localparam int GC = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [63:0] fr;
    logic        mute;
    logic        o_en;
    logic [15:0] o_freq;
    logic [3:0]  o_grant;
    logic [1:0]  o_state;
    int n_chk = 0;
    int n_pass = 0;
    // Model: playing flag, owner, cycles held, silent cycles still to go.
    bit m_play = 0;
    int m_owner = 0;
    int m_held = 0;
    int m_gap_left = 0;
    se_channel_arbiter #(.NUM_CH(4), .MIN_HOLD(32'd4), .GAP_CYCLES(32'd2)) dut (
        .iClock(clk), .iReset(rst), .iEnable(en), .iFreq(fr), .iMute(mute),
        .oEnable(o_en), .oFreq(o_freq), .oGrant(o_grant), .oState(o_state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask
    function automatic int top_req(input logic [3:0] e);
        for (int n = 3; n >= 0; n--) if (e[n]) return n;
        return -1;
    endfunction
    function automatic int chan_freq(input int n);
        logic [63:0] f;
        f = fr;
        return int'(f[n*16 +: 16]);
    endfunction
    task automatic model_step();
        int t;
        t = top_req(en);
        if (rst) begin
            m_play = 0; m_owner = 0; m_held = 0; m_gap_left = 0;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0 && t >= 0) begin
                m_play = 1; m_owner = t; m_held = 0;
            end
        end else if (m_play) begin
            if (!en[m_owner] || (t > m_owner && m_held >= MH)) begin
                m_play = 0; m_gap_left = GC;
            end else begin
                m_held = (m_held + 1 > MH) ? MH : m_held + 1;
            end
        end else if (t >= 0) begin
            m_play = 1; m_owner = t; m_held = 0;
        end
    endtask
    task automatic check_model();
        bit    x_en;
        int    x_state;
        x_en = m_play && !mute;
        x_state = m_play ? 1 : (m_gap_left > 0 ? 2 : 0);
        chk("state", 32'(o_state), 32'(x_state));
        chk("enable", 32'(o_en), 32'(x_en));
        chk("freq", 32'(o_freq), x_en ? 32'(chan_freq(m_owner)) : 32'd0);
        chk("grant", 32'(o_grant), m_play ? (32'd1 << m_owner) : 32'd0);
    endtask
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic set_freq(input int n, input int f);
        fr[n*16 +: 16] = 16'(f);
    endtask
    initial begin
        rst = 1'b1; en = 4'b0; fr = 64'd0; mute = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        rst = 1'b0;
        // Single source, one-cycle latency, then reset mid-play.
        en = 4'b0001; set_freq(0, 440);
        tick();
        chk("t1_en", 32'(o_en), 32'd1);
        chk("t1_freq", 32'(o_freq), 32'd440);
        chk("t1_grant", 32'(o_grant), 32'd1);
        repeat (3) tick();
        do_reset();
        chk("t1_rst_en", 32'(o_en), 32'd0);
        chk("t1_rst_freq", 32'(o_freq), 32'd0);
        chk("t1_rst_state", 32'(o_state), 32'd0);
        // Preemption by ch3 after ch0 has held long enough.
        en = 4'b0001;
        repeat (11) tick();
        en = 4'b1001; set_freq(3, 220);
        tick();
        chk("t2_gap1_state", 32'(o_state), 32'd2);
        chk("t2_gap1_freq", 32'(o_freq), 32'd0);
        tick();
        chk("t2_gap2_freq", 32'(o_freq), 32'd0);
        tick();
        chk("t2_grant", 32'(o_grant), 32'd8);
        chk("t2_freq", 32'(o_freq), 32'd220);
        // Minimum hold before preemption.
        do_reset();
        en = 4'b0010; set_freq(1, 330); set_freq(2, 262);
        tick();
        tick();
        en = 4'b0110;
        tick();
        tick();
        chk("t3_hold_grant", 32'(o_grant), 32'd2);
        repeat (6) tick();
        chk("t3_grant", 32'(o_grant), 32'd4);
        // Owner release with and without other requests.
        do_reset();
        en = 4'b0100;
        repeat (3) tick();
        en = 4'b0011;
        repeat (3) tick();
        chk("t4_grant", 32'(o_grant), 32'd2);
        do_reset();
        en = 4'b0100;
        repeat (2) tick();
        en = 4'b0000;
        repeat (3) tick();
        chk("t4_idle_state", 32'(o_state), 32'd0);
        chk("t4_idle_grant", 32'(o_grant), 32'd0);
        // Mute silences output but keeps grant and counters running.
        do_reset();
        en = 4'b1000; set_freq(3, 180);
        tick();
        mute = 1'b1;
        #1;
        chk("t5_mute_en", 32'(o_en), 32'd0);
        chk("t5_mute_freq", 32'(o_freq), 32'd0);
        chk("t5_mute_grant", 32'(o_grant), 32'd8);
        repeat (3) tick();
        mute = 1'b0;
        #1;
        chk("t5_unmute_freq", 32'(o_freq), 32'd180);
        tick();
        // Drop and re-assert inside the gap; then a live frequency sweep.
        do_reset();
        en = 4'b1010; set_freq(3, 220);
        repeat (6) tick();
        en = 4'b0010;
        tick();
        en = 4'b1010;
        tick();
        tick();
        chk("t6_grant", 32'(o_grant), 32'd8);
        for (int f = 220; f >= 50; f -= 10) begin
            set_freq(3, f);
            #1;
            chk("t6_sweep", 32'(o_freq), 32'(f));
            tick();
        end
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) en = 4'($urandom);
            if ($urandom_range(0, 2) == 0) fr = {$urandom, $urandom};
            mute = ($urandom_range(0, 9) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
